// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen
//
// Test-pattern pixel source for the 800x480 LCD timing controller. The
// controller presents look-ahead coordinates one cycle before the matching
// display-enable pixel. This block turns them into registered RGB888 data,
// so the data lines up with lcd_de.
//
// Four patterns are available: colour bars, a checkerboard, a gradient and a
// bouncing box. A debounced push-button steps through them. Mode changes and
// box motion only take effect at frame boundaries, so a frame never shows a
// mix of two states.
//
// Ports:
//   clk         pixel clock, shared with the LCD controller
//   rst_n       asynchronous active-low reset
//   btn_n       raw mode button, active-low, asynchronous to clk
//   lcd_de      display enable from the controller
//   lcd_xpos    look-ahead x coordinate (valid one cycle before lcd_de pixel)
//   lcd_ypos    look-ahead y coordinate
//   lcd_data    registered RGB888 pixel, one cycle after xpos/ypos
//   mode        current pattern (0 bars, 1 checker, 2 gradient, 3 box)
//   frame_tick  one-cycle pulse after the last DE cycle of the last line

module lcd_pattern_gen #(
  parameter int H_DISP          = 800,
  parameter int V_DISP          = 480,
  parameter int BOX_SIZE        = 64,
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 330000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_n,
  input  logic        lcd_de,
  input  logic [11:0] lcd_xpos,
  input  logic [11:0] lcd_ypos,
  output logic [23:0] lcd_data,
  output logic [1:0]  mode,
  output logic        frame_tick
);

  localparam int BAR_W = H_DISP / 8;
  localparam int X_MAX = H_DISP - BOX_SIZE;
  localparam int Y_MAX = V_DISP - BOX_SIZE;
  // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_BOX      = 2'd3
  } pattern_t;

  pattern_t mode_q;
  logic     pending;

  // ---------------------------------------------------------------------
  // Frame boundary detection
  // ---------------------------------------------------------------------
  logic        de_d;
  logic        de_valid;
  logic [11:0] line_y;

  // de_valid blocks the first cycle after reset. If reset is released while
  // DE is already high, that cycle looks like a rising edge, but the line is
  // partial and must not count as the last line of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_d     <= 1'b0;
      de_valid <= 1'b0;
      line_y   <= '0;
    end else begin
      de_d     <= lcd_de;
      de_valid <= 1'b1;
      if (lcd_de && !de_d && de_valid) begin
        line_y <= lcd_ypos;
      end
    end
  end

  // The pulse is taken straight from the DE falling edge. It is high on the
  // first non-DE cycle after the last line, so the state updates gated by it
  // land one cycle later, inside blanking.
  assign frame_tick = !lcd_de && de_d && (line_y == 12'(V_DISP - 1));

  // ---------------------------------------------------------------------
  // Button synchronizer and debounce
  // ---------------------------------------------------------------------
  logic             btn_meta;
  logic             btn_sync;
  logic             btn_level;
  logic             btn_level_next;
  logic [CNT_W-1:0] db_count;
  logic [CNT_W-1:0] db_count_next;
  logic             press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      btn_meta <= btn_n;
      btn_sync <= btn_meta;
    end
  end

  // The count runs only while the synchronized level disagrees with the
  // accepted level. Any cycle of agreement, such as a bounce back, clears it.
  // press is a single-cycle strobe on an accepted 1->0 change.
  always_comb begin
    btn_level_next = btn_level;
    db_count_next  = '0;
    press          = 1'b0;
    if (btn_sync != btn_level) begin
      if (db_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_level_next = btn_sync;
        press          = ~btn_sync;
      end else begin
        db_count_next = db_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= 1'b1;
      db_count  <= '0;
    end else begin
      btn_level <= btn_level_next;
      db_count  <= db_count_next;
    end
  end

  // ---------------------------------------------------------------------
  // Mode register
  // ---------------------------------------------------------------------
  // A press that is accepted on the tick cycle itself is folded into that
  // tick. Several presses within one frame collapse into one advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_BARS;
      pending <= 1'b0;
    end else if (frame_tick) begin
      if (pending || press) begin
        mode_q <= pattern_t'(mode_q + 2'd1);
      end
      pending <= 1'b0;
    end else if (press) begin
      pending <= 1'b1;
    end
  end

  assign mode = mode_q;

  // ---------------------------------------------------------------------
  // Bouncing box motion
  // ---------------------------------------------------------------------
  logic [11:0] box_x;
  logic [11:0] box_y;
  logic [11:0] box_x_next;
  logic [11:0] box_y_next;
  logic        dir_right;
  logic        dir_down;
  logic        dir_right_next;
  logic        dir_down_next;

  // The sums are done one bit wider, so the edge test cannot wrap. A step
  // that would reach or pass an edge clamps to that edge and reverses
  // direction.
  always_comb begin
    box_x_next     = box_x;
    box_y_next     = box_y;
    dir_right_next = dir_right;
    dir_down_next  = dir_down;

    if (dir_right) begin
      if (({1'b0, box_x} + 13'(STEP)) >= 13'(X_MAX)) begin
        box_x_next     = 12'(X_MAX);
        dir_right_next = 1'b0;
      end else begin
        box_x_next = box_x + 12'(STEP);
      end
    end else begin
      if (box_x <= 12'(STEP)) begin
        box_x_next     = '0;
        dir_right_next = 1'b1;
      end else begin
        box_x_next = box_x - 12'(STEP);
      end
    end

    if (dir_down) begin
      if (({1'b0, box_y} + 13'(STEP)) >= 13'(Y_MAX)) begin
        box_y_next    = 12'(Y_MAX);
        dir_down_next = 1'b0;
      end else begin
        box_y_next = box_y + 12'(STEP);
      end
    end else begin
      if (box_y <= 12'(STEP)) begin
        box_y_next    = '0;
        dir_down_next = 1'b1;
      end else begin
        box_y_next = box_y - 12'(STEP);
      end
    end
  end

  // The box moves on every tick in every mode, so its position keeps going
  // while another pattern is on screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x     <= '0;
      box_y     <= '0;
      dir_right <= 1'b1;
      dir_down  <= 1'b1;
    end else if (frame_tick) begin
      box_x     <= box_x_next;
      box_y     <= box_y_next;
      dir_right <= dir_right_next;
      dir_down  <= dir_down_next;
    end
  end

  // ---------------------------------------------------------------------
  // Pattern generation
  // ---------------------------------------------------------------------
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;
  logic [23:0] checker_rgb;
  logic [23:0] gradient_rgb;
  logic [23:0] box_rgb;
  logic        in_box;
  logic [23:0] pixel;

  // Threshold compares avoid a divider. Coordinates past the last bar stay
  // in bar 7.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (lcd_xpos >= 12'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  assign checker_rgb  = (lcd_xpos[5] ^ lcd_ypos[5]) ? 24'hFFFFFF : 24'h000000;
  assign gradient_rgb = {lcd_xpos[9:2], lcd_ypos[8:1], 8'h80};

  assign in_box = (lcd_xpos >= box_x) &&
                  ({1'b0, lcd_xpos} < ({1'b0, box_x} + 13'(BOX_SIZE))) &&
                  (lcd_ypos >= box_y) &&
                  ({1'b0, lcd_ypos} < ({1'b0, box_y} + 13'(BOX_SIZE)));
  assign box_rgb = in_box ? 24'hFFFFFF : 24'h000040;

  always_comb begin
    pixel = bar_rgb;
    case (mode_q)
      MODE_BARS:     pixel = bar_rgb;
      MODE_CHECKER:  pixel = checker_rgb;
      MODE_GRADIENT: pixel = gradient_rgb;
      MODE_BOX:      pixel = box_rgb;
      default:       pixel = bar_rgb;
    endcase
  end

  // Data is registered on every cycle. Blanking outside DE is handled by the
  // downstream stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_data <= '0;
    end else begin
      lcd_data <= pixel;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen
//
// Self-checking bench for lcd_pattern_gen. It drives a compressed LCD
// controller: short lines, with DE delayed one cycle after the look-ahead
// coordinates. It checks lcd_data, mode and frame_tick on every cycle against
// a reference model. The model derives box position from the tick count as a
// triangle wave, and pixels from plain arithmetic on the coordinates.
//
// Ports: none (top-level bench).

module tb_lcd_pattern_gen;

  localparam int DEB = 16;

  logic        clk;
  logic        rst_n;
  logic        btn_n;
  logic        lcd_de;
  logic [11:0] lcd_xpos;
  logic [11:0] lcd_ypos;
  logic [23:0] lcd_data;
  logic [1:0]  mode;
  logic        frame_tick;

  lcd_pattern_gen #(
    .H_DISP(800),
    .V_DISP(480),
    .BOX_SIZE(64),
    .STEP(4),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .lcd_de(lcd_de),
    .lcd_xpos(lcd_xpos),
    .lcd_ypos(lcd_ypos),
    .lcd_data(lcd_data),
    .mode(mode),
    .frame_tick(frame_tick)
  );

  // 100 MHz bench clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int mode_m;
  bit pending_m;
  int ticks_m;
  int tick_seen;
  bit de_next;
  int xq[$];

  // Box travel is a triangle wave over the tick count. Each leg is lim/4
  // ticks long.
  function automatic int tri_pos(input int k, input int lim);
    int n;
    int p;
    n = lim / 4;
    p = k % (2 * n);
    return (p <= n) ? 4 * p : 4 * (2 * n - p);
  endfunction

  function automatic logic [23:0] model_pixel(input int m, input int x, input int y,
                                              input int bx, input int by);
    int idx;
    logic [23:0] rgb;
    rgb = 24'h000000;
    case (m)
      0: begin
        idx = x / 100;
        if (idx > 7) idx = 7;
        case (idx)
          0: rgb = 24'hFFFFFF;
          1: rgb = 24'hFFFF00;
          2: rgb = 24'h00FFFF;
          3: rgb = 24'h00FF00;
          4: rgb = 24'hFF00FF;
          5: rgb = 24'hFF0000;
          6: rgb = 24'h0000FF;
          default: rgb = 24'h000000;
        endcase
      end
      1: rgb = (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      2: rgb = {8'((x / 4) % 256), 8'((y / 2) % 256), 8'h80};
      default: rgb = (x >= bx && x < bx + 64 && y >= by && y < by + 64) ?
                     24'hFFFFFF : 24'h000040;
    endcase
    return rgb;
  endfunction

  task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pixel-clock cycle. DE follows the previous cycle's active flag, and
  // the registered data is checked after the edge.
  task automatic applyStimulus(input bit active, input int x, input int y, input bit exp_tick);
    logic [23:0] exp_data;
    lcd_de   = de_next;
    de_next  = active;
    lcd_xpos = 12'(x);
    lcd_ypos = 12'(y);
    #1;
    if (frame_tick === 1'b1) tick_seen++;
    checkOutput("frame_tick", {23'd0, frame_tick}, {23'd0, exp_tick});
    checkOutput("mode", {22'd0, mode}, 24'(mode_m));
    exp_data = rst_n ? model_pixel(mode_m, x, y, tri_pos(ticks_m, 736), tri_pos(ticks_m, 416))
                     : 24'h000000;
    @(posedge clk);
    #1;
    checkOutput("lcd_data", lcd_data, exp_data);
    if (exp_tick && rst_n) begin
      ticks_m++;
      if (pending_m) mode_m = (mode_m + 1) % 4;
      pending_m = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom_range(0, 799), 500, 1'b0);
  endtask

  // Active pixels take x from xq while it has entries. rel_at >= 0 releases
  // reset at that active index, which leaves the line incomplete.
  task automatic runLine(input int y, input int na, input int nb, input int rel_at);
    int x;
    for (int i = 0; i < na; i++) begin
      if (i == rel_at) rst_n = 1'b1;
      x = (xq.size() > 0) ? xq.pop_front() : int'($urandom_range(0, 799));
      applyStimulus(1'b1, x, y, 1'b0);
    end
    for (int j = 0; j < nb; j++) begin
      applyStimulus(1'b0, $urandom_range(0, 799), y,
                    (j == 1) && (y == 479) && (rel_at < 0));
    end
  endtask

  task automatic tickLine();
    runLine(479, 2, 3, -1);
  endtask

  task automatic runFrame(input int first_y);
    for (int y = first_y; y < 480; y++) runLine(y, 3, 3, -1);
  endtask

  task automatic randomLines(input int n);
    for (int i = 0; i < n; i++) runLine($urandom_range(0, 478), 4, 3, -1);
  endtask

  task automatic pressButton(input int bounces, input bit hold);
    for (int b = 0; b < bounces; b++) begin
      btn_n = 1'b0;
      idle(1);
      btn_n = 1'b1;
      idle(1);
    end
    if (hold) begin
      btn_n = 1'b0;
      idle(DEB + 8);
      pending_m = 1'b1;
    end
    btn_n = 1'b1;
    idle(DEB + 8);
  endtask

  task automatic modelReset();
    mode_m    = 0;
    pending_m = 1'b0;
    ticks_m   = 0;
    de_next   = 1'b0;
    lcd_de    = 1'b0;
    btn_n     = 1'b1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_lcd_data", lcd_data, 24'h000000);
    checkOutput("reset_mode", {22'd0, mode}, 24'h0);
    checkOutput("reset_frame_tick", {23'd0, frame_tick}, 24'h0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    tick_seen = 0;
    rst_n     = 1'b0;
    btn_n     = 1'b1;
    lcd_de    = 1'b0;
    lcd_xpos  = '0;
    lcd_ypos  = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    doReset();

    $display("[TB] colour bars");
    xq = '{0, 99, 100, 700, 799};
    runLine(10, 5, 3, -1);
    randomLines(4);

    $display("[TB] full frames");
    for (int f = 0; f < 2; f++) begin
      tick_seen = 0;
      runFrame(0);
      checkOutput("ticks_per_frame", 24'(tick_seen), 24'd1);
    end

    $display("[TB] reset released at line 200");
    doReset();
    tick_seen = 0;
    runFrame(200);
    checkOutput("ticks_after_reset_l200", 24'(tick_seen), 24'd1);

    $display("[TB] reset released inside line 479");
    rst_n = 1'b0;
    modelReset();
    tick_seen = 0;
    runLine(479, 6, 3, 3);
    checkOutput("no_tick_partial_line", 24'(tick_seen), 24'd0);
    tickLine();
    checkOutput("tick_full_line", 24'(tick_seen), 24'd1);

    $display("[TB] button presses");
    pressButton(0, 1'b1);
    pressButton(0, 1'b1);
    checkOutput("mode_pending", {22'd0, mode}, 24'd0);
    tickLine();
    idle(2);
    checkOutput("mode_two_presses", {22'd0, mode}, 24'd1);
    pressButton(4, 1'b1);
    checkOutput("mode_bounce_pending", {22'd0, mode}, 24'd1);
    tickLine();
    idle(2);
    checkOutput("mode_bounce_press", {22'd0, mode}, 24'd2);
    pressButton(5, 1'b0);
    tickLine();
    idle(2);
    checkOutput("mode_bounce_only", {22'd0, mode}, 24'd2);
    randomLines(4);

    $display("[TB] reset with pending press");
    pressButton(0, 1'b1);
    doReset();
    tickLine();
    idle(2);
    checkOutput("mode_after_reset_frame", {22'd0, mode}, 24'd0);

    $display("[TB] mode wrap");
    for (int i = 0; i < 4; i++) begin
      pressButton(0, 1'b1);
      tickLine();
      randomLines(3);
      checkOutput("mode_wrap", {22'd0, mode}, 24'((i + 1) % 4));
    end

    $display("[TB] bouncing box");
    for (int i = 0; i < 3; i++) begin
      pressButton(0, 1'b1);
      tickLine();
    end
    checkOutput("mode_box", {22'd0, mode}, 24'd3);
    for (int t = 0; t < 380; t++) begin
      int bx;
      int by;
      int y2;
      bx = tri_pos(ticks_m, 736);
      by = tri_pos(ticks_m, 416);
      xq = '{bx, bx + 63, bx + 64};
      if (bx > 0) xq.push_back(bx - 1);
      runLine(by, xq.size(), 3, -1);
      y2 = by + 63 + int'($urandom_range(0, 1));
      if (y2 == 479) y2 = 480;
      xq = '{bx, bx + 63};
      runLine(y2, 2, 3, -1);
      tickLine();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
